alu_control_mc: RTL and testbench

//  Second-generation ALU control: decodes ALUOp/FuncField into Operation and branch_type like the

---
 rtl/alu_control_mc_if.sv | 26 ++
 rtl/alu_control_mc.sv | 168 ++++++++++++++++
 tb/tb_alu_control_mc.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_mc_if.sv
// Handshake and decode bus between the main control unit and the multi-cycle ALU control block.
interface alu_control_mc_if #(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 6,
    parameter int BR_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   ALUOp;
    logic [FUNC_W-1:0] FuncField;
    logic [OP_W-1:0]   Operation;
    logic [BR_W-1:0]   branch_type;
    logic              out_valid;
    logic              stall;
    logic              illegal_op;

    modport master (
        output in_valid, ALUOp, FuncField,
        input  in_ready, Operation, branch_type, out_valid, stall, illegal_op
    );

    modport slave (
        input  in_valid, ALUOp, FuncField,
        output in_ready, Operation, branch_type, out_valid, stall, illegal_op
    );
endinterface

// File: rtl/alu_control_mc.sv
// Registered ALU control decoder that sequences multi-cycle mul/div and stalls the pipeline meanwhile.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to trap unknown ALUOp/funct codes on a sticky illegal_op flag.
module alu_control_mc #(
    parameter int OP_W       = 4,
    parameter int FUNC_W     = 6,
    parameter int BR_W       = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_control_mc_if.slave   bus
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state, w_nextState;
    logic [CNT_W-1:0]  r_cnt, w_nextCnt;
    logic [OP_W-1:0]   r_operation, w_nextOperation;
    logic [BR_W-1:0]   r_branchType, w_nextBranchType;
    logic              r_outValid, w_nextOutValid;

    logic [OP_W-1:0]   w_decOp;
    logic [BR_W-1:0]   w_decBr;
    logic              w_decLong;
    logic              w_decDiv;
    logic              w_accept;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic              w_decIllegal;
    logic              r_illegal;
`endif

    assign w_accept = bus.in_valid && (r_state == IDLE);

    // Pure decode of the incoming op; branch_type defaults to none so it can never be held over.
    always_comb begin
        w_decOp   = OP_W'(4'b1111);
        w_decBr   = '0;
        w_decLong = 1'b0;
        w_decDiv  = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        w_decIllegal = 1'b0;
`endif
        case (bus.ALUOp)
            OP_W'(4'b0000): w_decOp = OP_W'(4'b0000);
            OP_W'(4'b0001): w_decOp = OP_W'(4'b1000);
            OP_W'(4'b0011): w_decOp = OP_W'(4'b1001);
            OP_W'(4'b0100): begin w_decOp = OP_W'(4'b0001); w_decBr = BR_W'(3'b001); end
            OP_W'(4'b0101): begin w_decOp = OP_W'(4'b0001); w_decBr = BR_W'(3'b010); end
            OP_W'(4'b0110): begin w_decOp = OP_W'(4'b1110); w_decBr = BR_W'(3'b011); end
            OP_W'(4'b0111): begin w_decOp = OP_W'(4'b1101); w_decBr = BR_W'(3'b100); end
            OP_W'(4'b1000): begin w_decOp = OP_W'(4'b1100); w_decBr = BR_W'(3'b101); end
            OP_W'(4'b1001): begin w_decOp = OP_W'(4'b1100); w_decBr = BR_W'(3'b110); end
            OP_W'(4'b0010): begin
                case (bus.FuncField)
                    FUNC_W'(6'b100000): w_decOp = OP_W'(4'b0000);
                    FUNC_W'(6'b100010): w_decOp = OP_W'(4'b0001);
                    FUNC_W'(6'b011000): begin w_decOp = OP_W'(4'b0010); w_decLong = 1'b1; end
                    FUNC_W'(6'b011010): begin
                        w_decOp   = OP_W'(4'b0011);
                        w_decLong = 1'b1;
                        w_decDiv  = 1'b1;
                    end
                    FUNC_W'(6'b000000): w_decOp = OP_W'(4'b0100);
                    FUNC_W'(6'b000010): w_decOp = OP_W'(4'b0101);
                    FUNC_W'(6'b100100): w_decOp = OP_W'(4'b1000);
                    FUNC_W'(6'b100101): w_decOp = OP_W'(4'b1001);
                    FUNC_W'(6'b100110): w_decOp = OP_W'(4'b1010);
                    FUNC_W'(6'b100111): w_decOp = OP_W'(4'b1011);
                    FUNC_W'(6'b101010): w_decOp = OP_W'(4'b1110);
                    FUNC_W'(6'b100001): w_decOp = OP_W'(4'b0110);
                    FUNC_W'(6'b100011): w_decOp = OP_W'(4'b0111);
                    default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                        w_decOp      = OP_W'(4'b1111);
                        w_decIllegal = 1'b1;
`else
                        w_decOp      = OP_W'(4'b0000);
`endif
                    end
                endcase
            end
            default: begin
                w_decOp = OP_W'(4'b1111);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                w_decIllegal = 1'b1;
`endif
            end
        endcase
    end

    // BUSY always leaves on cnt==1, so the counter can never wrap below zero.
    always_comb begin
        w_nextState      = r_state;
        w_nextCnt        = r_cnt;
        w_nextOperation  = r_operation;
        w_nextBranchType = r_branchType;
        w_nextOutValid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextOperation  = w_decOp;
                    w_nextBranchType = w_decBr;
                    if (w_decLong) begin
                        w_nextState = BUSY;
                        w_nextCnt   = w_decDiv ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        w_nextOutValid = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    w_nextState    = IDLE;
                    w_nextCnt      = '0;
                    w_nextOutValid = 1'b1;
                end else begin
                    w_nextCnt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_operation  <= '0;
            r_branchType <= '0;
            r_outValid   <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_cnt        <= w_nextCnt;
            r_operation  <= w_nextOperation;
            r_branchType <= w_nextBranchType;
            r_outValid   <= w_nextOutValid;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_accept && w_decIllegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign bus.illegal_op = r_illegal;
`else
    assign bus.illegal_op = 1'b0;
`endif

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.stall       = (r_state == BUSY);
    assign bus.Operation   = r_operation;
    assign bus.branch_type = r_branchType;
    assign bus.out_valid   = r_outValid;
endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: directed scenarios plus randomized ops against a cycle-level model.
// Honours ALU_CTRL_ILLEGAL_TRAP_EN the same way the design does.
module tb_alu_control_mc;
    localparam int MUL_N = 4;
    localparam int DIV_N = 16;

    // Legal R-type functs and their ALU codes; index 2 is mul, index 3 is div.
    localparam logic [5:0] FUNCTS [13] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010,
                                           6'b000000, 6'b000010, 6'b100100, 6'b100101,
                                           6'b100110, 6'b100111, 6'b101010, 6'b100001,
                                           6'b100011};
    localparam logic [3:0] FOPS [13]   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8,
                                           4'h9, 4'hA, 4'hB, 4'hE, 4'h6, 4'h7};
    // Branch ALUOps 0100..1001 map in order to these operations; branch_type is ALUOp-3.
    localparam logic [3:0] BR_OPS [6]  = '{4'h1, 4'h1, 4'hE, 4'hD, 4'hC, 4'hC};

    logic clk;
    logic rst_n;
    alu_control_mc_if #(.OP_W(4), .FUNC_W(6), .BR_W(3)) bus ();

    alu_control_mc #(
        .OP_W(4), .FUNC_W(6), .BR_W(3), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int         mBusyLeft;
    logic [3:0] mOp;
    logic [2:0] mBr;
    logic       mValid;
    logic       mIllegal;

    function automatic void refDecode(input logic [3:0] aluOp, input logic [5:0] funct,
                                      output logic [3:0] op, output logic [2:0] br,
                                      output int cycles, output logic illegal);
        bit found;
        op = 4'hF; br = 3'b000; cycles = 1; illegal = 1'b0; found = 0;
        if (aluOp == 4'h0)                    op = 4'h0;
        else if (aluOp == 4'h1)               op = 4'h8;
        else if (aluOp == 4'h3)               op = 4'h9;
        else if (aluOp >= 4'h4 && aluOp <= 4'h9) begin
            op = BR_OPS[int'(aluOp) - 4];
            br = 3'(int'(aluOp) - 3);
        end else if (aluOp == 4'h2) begin
            for (int i = 0; i < 13; i++) begin
                if (FUNCTS[i] == funct) begin
                    op = FOPS[i];
                    found = 1;
                    if (i == 2) cycles = MUL_N;
                    if (i == 3) cycles = DIV_N;
                end
            end
            if (!found) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                op = 4'hF; illegal = 1'b1;
`else
                op = 4'h0;
`endif
            end
        end else begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal = 1'b1;
`endif
        end
    endfunction

    task automatic modelReset();
        mBusyLeft = 0; mOp = 4'h0; mBr = 3'b000; mValid = 1'b0; mIllegal = 1'b0;
    endtask

    task automatic modelClock(input logic v, input logic [3:0] aluOp, input logic [5:0] funct);
        logic [3:0] op;
        logic [2:0] br;
        int         cycles;
        logic       ill;
        if (mBusyLeft > 0) begin
            mBusyLeft--;
            mValid = (mBusyLeft == 0);
        end else if (v) begin
            refDecode(aluOp, funct, op, br, cycles, ill);
            mOp = op; mBr = br;
            if (ill) mIllegal = 1'b1;
            mBusyLeft = cycles - 1;
            mValid = (cycles == 1);
        end else begin
            mValid = 1'b0;
        end
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".Operation"},   32'(bus.Operation),   32'(mOp));
        checkOne({tag, ".branch_type"}, 32'(bus.branch_type), 32'(mBr));
        checkOne({tag, ".out_valid"},   32'(bus.out_valid),   32'(mValid));
        checkOne({tag, ".stall"},       32'(bus.stall),       32'(mBusyLeft > 0));
        checkOne({tag, ".in_ready"},    32'(bus.in_ready),    32'(mBusyLeft == 0));
        checkOne({tag, ".illegal_op"},  32'(bus.illegal_op),  32'(mIllegal));
    endtask

    // Drive one cycle of inputs at the falling edge, step the model on the rising edge, check at the next fall.
    task automatic applyStimulus(input string tag, input logic v, input logic [3:0] aluOp,
                                 input logic [5:0] funct);
        bus.in_valid  = v;
        bus.ALUOp     = aluOp;
        bus.FuncField = funct;
        @(posedge clk);
        modelClock(v, aluOp, funct);
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic pulseReset(input string tag);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rAlu;
        logic [5:0] rFunct;
        logic       rValid;

        bus.in_valid  = 1'b0;
        bus.ALUOp     = 4'h0;
        bus.FuncField = 6'h0;
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("t1_sub", 1'b1, 4'b0010, 6'b100010);
        checkOne("t1_op_const", 32'(bus.Operation), 32'h1);
        checkOne("t1_valid_const", 32'(bus.out_valid), 32'h1);

        applyStimulus("t2_mul", 1'b1, 4'b0010, 6'b011000);
        for (int i = 1; i < MUL_N; i++) begin
            applyStimulus("t2_busy", 1'b0, 4'h0, 6'h0);
        end
        checkOne("t2_done_valid", 32'(bus.out_valid), 32'h1);
        checkOne("t2_done_ready", 32'(bus.in_ready), 32'h1);

        applyStimulus("t3_bgt", 1'b1, 4'b0110, 6'h0);
        checkOne("t3_bgt_br", 32'(bus.branch_type), 32'h3);
        applyStimulus("t3_andi", 1'b1, 4'b0001, 6'h0);
        checkOne("t3_andi_br", 32'(bus.branch_type), 32'h0);
        applyStimulus("idle_hold", 1'b0, 4'h5, 6'h3);

        applyStimulus("t4_div", 1'b1, 4'b0010, 6'b011010);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("t4_busy", 1'b0, 4'h0, 6'h0);
        end
        pulseReset("t4_reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t4_after", 1'b0, 4'h0, 6'h0);
        end

        applyStimulus("t5_badfunct", 1'b1, 4'b0010, 6'b111111);
        applyStimulus("t5_next", 1'b1, 4'b0000, 6'h0);
        applyStimulus("t5_badaluop", 1'b1, 4'b1110, 6'h0);
        applyStimulus("t5_sticky", 1'b0, 4'h0, 6'h0);

        applyStimulus("t6_div", 1'b1, 4'b0010, 6'b011010);
        for (int i = 1; i < DIV_N; i++) begin
            applyStimulus("t6_held", 1'b1, 4'b0010, 6'b100010);
        end
        checkOne("t6_ready_at_n", 32'(bus.in_ready), 32'h1);
        applyStimulus("t6_next", 1'b1, 4'b0010, 6'b100010);
        checkOne("t6_next_op", 32'(bus.Operation), 32'h1);

        for (int i = 0; i < 400; i++) begin
            rValid = ($urandom_range(0, 3) != 0);
            rAlu   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) rAlu = 4'h2;
            if ($urandom_range(0, 3) != 0) begin
                rFunct = FUNCTS[$urandom_range(0, 12)];
            end else begin
                rFunct = 6'($urandom);
            end
            applyStimulus("rand", rValid, rAlu, rFunct);
            if (i == 200) pulseReset("rand_reset");
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
